vga_tile_buffer: RTL and testbench

Tile-based video memory sitting directly upstream of `vga_output`: it consumes the `pixel_counter`/`line_counter` pair from `vga_counter` and produces the 8-bit `color_internal` (rrr_ggg_bb) that `vga_output` registers onto the pins. The screen is 80×60 tiles of 8×8 pixels, one colour byte per tile. The CPU side writes tiles through a valid/ready port into a small FIFO. The FIFO drains into the single-port tile RAM only while the raster is outside the visible area, so display reads never stall.

---
 rtl/vga_tile_buffer.sv | 134 +++++++++++++
 tb/tb_vga_tile_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_buffer.sv
// Tile colour memory for the VGA raster: 8x8-pixel tiles, one rrr_ggg_bb byte each.
// CPU writes queue in a small FIFO and drain into the tile RAM only during blanking.
module vga_tile_buffer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TILES_X    = 80,
  parameter int TILES_Y    = 60,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [9:0]                    pixel_counter,
  input  logic [9:0]                    line_counter,
  input  logic                          wr_valid,
  input  logic [12:0]                   wr_addr,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wr_error,
  output logic [7:0]                    color_internal
);

  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int NTILES = TILES_X * TILES_Y;

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [12:0]   NTILES_C   = 13'(NTILES);
  localparam logic [12:0]   TILES_X_C  = 13'(TILES_X);
  localparam logic [9:0]    H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACTIVE_C = 10'(V_ACTIVE);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_error_q, wr_error_d;
  logic          flag1_q, flag1_d;
  logic [7:0]    color_q, color_d;
  logic [7:0]    rd_data_q;

  logic [12:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]    fifo_data_mem [FIFO_DEPTH];
  logic [7:0]    tile_ram      [NTILES];

  logic          active;
  logic          push;
  logic          pop;
  logic [12:0]   rd_addr;
  logic [12:0]   head_addr;
  logic [7:0]    head_data;
  logic          head_in_range;
  logic          ram_we;
  logic [12:0]   ram_addr;

  assign active = (pixel_counter < H_ACTIVE_C) && (line_counter < V_ACTIVE_C);
  assign rd_addr = 13'(line_counter[9:3]) * TILES_X_C + 13'(pixel_counter[9:3]);

  assign head_addr     = fifo_addr_mem[head_q];
  assign head_data     = fifo_data_mem[head_q];
  assign head_in_range = head_addr < NTILES_C;

  assign wr_ready = count_q < DEPTH_C;
  assign push     = wr_valid && wr_ready;
  assign pop      = (count_q != '0) && enable && !active;

  // Reads own the single RAM port during the visible area, the drain owns it otherwise.
  assign ram_we   = pop && head_in_range;
  assign ram_addr = active ? rd_addr : head_addr;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wr_error_d = wr_error_q;
    flag1_d    = active && enable;
    color_d    = flag1_q ? rd_data_q : 8'h00;

    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
      if (!head_in_range) begin
        wr_error_d = 1'b1;
      end
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_error_q <= 1'b0;
      flag1_q    <= 1'b0;
      color_q    <= 8'h00;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_error_q <= wr_error_d;
      flag1_q    <= flag1_d;
      color_q    <= color_d;
    end
  end

  // FIFO payload needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[tail_q] <= wr_addr;
      fifo_data_mem[tail_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      tile_ram[ram_addr] <= head_data;
    end
    if (active) begin
      rd_data_q <= tile_ram[ram_addr];
    end
  end

  assign fifo_count     = count_q;
  assign wr_error       = wr_error_q;
  assign color_internal = color_q;

endmodule

// File: tb/tb_vga_tile_buffer.sv
// Directed bench for vga_tile_buffer: table of tile reads plus hand-written
// sequences for fill/drain, error, push/pop overlap, enable and reset corners.
module tb_vga_tile_buffer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [9:0]  pixel_counter;
  logic [9:0]  line_counter;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [2:0]  fifo_count;
  logic        wr_error;
  logic [7:0]  color_internal;

  int total;
  int bad;

  vga_tile_buffer #(
    .FIFO_DEPTH(4),
    .TILES_X(80),
    .TILES_Y(60),
    .H_ACTIVE(640),
    .V_ACTIVE(480)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pixel_counter(pixel_counter),
    .line_counter(line_counter),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .fifo_count(fifo_count),
    .wr_error(wr_error),
    .color_internal(color_internal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] px;
    logic [9:0] ln;
    logic       en;
    logic [7:0] exp_color;
  } rd_vec_t;

  rd_vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic set_pos(input logic [9:0] px, input logic [9:0] ln);
    pixel_counter = px;
    line_counter  = ln;
  endtask

  task automatic push(input logic [12:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Counters sampled on the first edge, colour registered on the second.
  task automatic rd_check(input string name, input logic [9:0] px, input logic [9:0] ln,
                          input logic [7:0] exp);
    set_pos(px, ln);
    tick();
    tick();
    check(name, 16'(color_internal), 16'(exp));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{"rd_tile0_origin",   10'd0,   10'd0,   1'b1, 8'hE0};
    vecs[1] = '{"rd_tile0_corner",   10'd7,   10'd7,   1'b1, 8'hE0};
    vecs[2] = '{"rd_tile4799",       10'd639, 10'd479, 1'b1, 8'h03};
    vecs[3] = '{"rd_tile2",          10'd16,  10'd0,   1'b1, 8'h55};
    vecs[4] = '{"rd_tile81_first",   10'd8,   10'd8,   1'b1, 8'h1C};
    vecs[5] = '{"rd_tile81_last",    10'd15,  10'd15,  1'b1, 8'h1C};
    vecs[6] = '{"rd_enable_low",     10'd8,   10'd8,   1'b0, 8'h00};
    vecs[7] = '{"rd_hblank_black",   10'd700, 10'd0,   1'b1, 8'h00};
    vecs[8] = '{"rd_vblank_black",   10'd0,   10'd500, 1'b1, 8'h00};

    reset = 1'b0;
    enable = 1'b1;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    set_pos(10'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_ready", 16'(wr_ready), 16'd1);
    check("reset_color", 16'(color_internal), 16'h00);
    check("reset_count", 16'(fifo_count), 16'd0);
    check("reset_wr_error", 16'(wr_error), 16'd0);
    reset = 1'b1;

    // Fill during the visible area; nothing may drain.
    set_pos(10'd100, 10'd10);
    push(13'd0,    8'hE0);
    push(13'd4799, 8'h03);
    push(13'd81,   8'h1C);
    push(13'd2,    8'h55);
    check("fill_count4", 16'(fifo_count), 16'd4);
    check("fill_not_ready", 16'(wr_ready), 16'd0);
    set_pos(10'd639, 10'd10);
    tick();
    tick();
    check("no_drain_at_639", 16'(fifo_count), 16'd4);

    set_pos(10'd640, 10'd10);
    tick();
    tick();
    check("drain_two_cycles", 16'(fifo_count), 16'd2);
    tick();
    tick();
    check("drain_empty", 16'(fifo_count), 16'd0);
    check("drain_ready", 16'(wr_ready), 16'd1);

    for (int i = 0; i < 9; i++) begin
      enable = vecs[i].en;
      $display("rd px=%0d ln=%0d en=%0d", vecs[i].px, vecs[i].ln, vecs[i].en);
      rd_check(vecs[i].name, vecs[i].px, vecs[i].ln, vecs[i].exp_color);
    end
    enable = 1'b1;

    // Out-of-range address is discarded and latches the error flag.
    set_pos(10'd100, 10'd10);
    push(13'd4800, 8'hFF);
    check("oor_queued", 16'(fifo_count), 16'd1);
    check("oor_no_err_yet", 16'(wr_error), 16'd0);
    set_pos(10'd640, 10'd10);
    tick();
    check("oor_err_set", 16'(wr_error), 16'd1);
    check("oor_drained", 16'(fifo_count), 16'd0);
    set_pos(10'd700, 10'd520);
    tick();
    tick();
    check("oor_err_sticky", 16'(wr_error), 16'd1);
    rd_check("oor_tile0_kept", 10'd0, 10'd0, 8'hE0);

    // A tile drained on one edge is readable by a sample on the very next edge.
    set_pos(10'd100, 10'd10);
    push(13'd40, 8'h99);
    set_pos(10'd640, 10'd0);
    tick();
    rd_check("drain_then_read", 10'd320, 10'd0, 8'h99);

    // Push and pop on the same edge leave the count unchanged.
    set_pos(10'd100, 10'd10);
    push(13'd3, 8'h11);
    push(13'd4, 8'h22);
    check("pp_count2", 16'(fifo_count), 16'd2);
    set_pos(10'd640, 10'd10);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 13'(10 + i);
      wr_data  = 8'(8'hA0 + i);
      tick();
      check($sformatf("pp_hold_%0d", i), 16'(fifo_count), 16'd2);
    end
    set_pos(10'd100, 10'd10);
    wr_addr = 13'd13;
    wr_data = 8'hA3;
    tick();
    check("pp_rise3", 16'(fifo_count), 16'd3);
    wr_addr = 13'd14;
    wr_data = 8'hA4;
    tick();
    check("pp_rise4", 16'(fifo_count), 16'd4);
    check("pp_full_not_ready", 16'(wr_ready), 16'd0);
    wr_valid = 1'b0;
    set_pos(10'd640, 10'd10);
    repeat (4) tick();
    check("pp_drained", 16'(fifo_count), 16'd0);
    rd_check("pp_tile10", 10'd80, 10'd0, 8'hA0);
    rd_check("pp_tile14", 10'd112, 10'd0, 8'hA4);
    rd_check("pp_tile3", 10'd24, 10'd0, 8'h11);

    // Drain frozen while disabled, resumes once enabled.
    enable = 1'b0;
    set_pos(10'd100, 10'd10);
    push(13'd20, 8'h77);
    check("en_queued", 16'(fifo_count), 16'd1);
    set_pos(10'd640, 10'd10);
    repeat (3) tick();
    check("en_frozen", 16'(fifo_count), 16'd1);
    enable = 1'b1;
    tick();
    check("en_resumed", 16'(fifo_count), 16'd0);
    rd_check("en_tile20", 10'd160, 10'd0, 8'h77);

    // Asynchronous reset with entries queued.
    set_pos(10'd100, 10'd10);
    push(13'd30, 8'h33);
    push(13'd31, 8'h34);
    push(13'd32, 8'h35);
    check("rst_pre_count3", 16'(fifo_count), 16'd3);
    reset = 1'b0;
    #1;
    check("rst_async_count", 16'(fifo_count), 16'd0);
    check("rst_async_ready", 16'(wr_ready), 16'd1);
    check("rst_async_err", 16'(wr_error), 16'd0);
    check("rst_async_color", 16'(color_internal), 16'h00);
    set_pos(10'd640, 10'd10);
    tick();
    tick();
    reset = 1'b1;
    rd_check("rst_keep_tile0", 10'd0, 10'd0, 8'hE0);
    rd_check("rst_keep_tile4799", 10'd639, 10'd479, 8'h03);
    rd_check("rst_keep_tile10", 10'd80, 10'd0, 8'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
